channel_entry_ctrl: RTL and testbench
=====================================

Name: channel_entry_ctrl

Overview:
Remote-control channel controller. It takes decoded key presses (digits, CH+/CH-, ENTER), runs two-digit channel entry with a timeout, and holds the committed channel. It drives the tens/units digit inputs of the 7-segment BCD decoder stage, and the displayed digits follow entry progress.

Parameters:
MIN_CH, 1, lowest legal channel (0..99, must be <= MAX_CH)
MAX_CH, 99, highest legal channel (MIN_CH..99)
TIMEOUT_CYC, 50000000, idle cycles after a first digit before auto-commit (>= 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit; 10 CH_UP; 11 CH_DOWN; 12 ENTER; 13-15 reserved
unit_digit  out  8  units digit to BCD decoder, 0..9, bits [7:4]=0
tens_digit  out  8  tens digit to BCD decoder, 0..9, bits [7:4]=0
channel  out  7  committed channel, binary
ch_changed  out  1  one-cycle pulse when channel takes a new, different value
entry_active  out  1  high while state = FIRST

Behaviour:
- One clock; reset asynchronous and active-low; all state and outputs registered.
- Reset: state IDLE, channel=MIN_CH, tens_digit/unit_digit = digits of MIN_CH, ch_changed=0, entry_active=0, timeout counter=0, pending digit=0. Reset mid-entry drops the pending digit.
- States: IDLE, FIRST.
- IDLE, digit d: pending=d, counter=0, go to FIRST. Display tens=0, units=d. Channel unchanged.
- IDLE, CH_UP: channel+1, wraps MAX_CH->MIN_CH. CH_DOWN: channel-1, wraps MIN_CH->MAX_CH.
- IDLE, ENTER or a reserved code: no effect.
- FIRST, digit e: candidate=10*pending+e. If MIN_CH<=candidate<=MAX_CH, commit it; else discard. Either way, go to IDLE.
- FIRST, ENTER: candidate=pending; commit if in range, else discard; go to IDLE.
- FIRST, CH_UP/CH_DOWN: abort entry, apply the up/down to the committed channel, go to IDLE.
- FIRST, reserved code: ignored; counter keeps running.
- FIRST, no key: counter increments each cycle. On the TIMEOUT_CYC-th rising edge after the edge that accepted the first digit, candidate=pending is committed/discarded as for ENTER, and state returns to IDLE.
- A key on the same edge the timeout would fire takes priority; timeout is suppressed.
- Latency: the key is sampled at edge k; channel, digits and state are updated at edge k. ch_changed is high for exactly the cycle after edge k, and only if the new channel != the old channel.
- Digits shown in IDLE: tens=channel/10, units=channel%10. A discarded entry restores these digits at the same edge.
- key_valid with key_code 13-15 never changes state or outputs (unless the optional feature is enabled).

Optional Feature:
LAST_CH_EN
- Defined: a register prev_ch, reset to MIN_CH, takes the old channel on every channel change. key_code 13 (RECALL) in IDLE or FIRST aborts any entry and swaps channel with prev_ch; ch_changed pulses if the values differ.
- Undefined: no prev_ch register; code 13 is reserved and ignored like 14-15.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> outputs reset immediately; channel=1, tens=0, units=1, ch_changed=0.
2. Two-digit entry: keys 4, then 2 -> after the '4' edge: entry_active=1, units=4, tens=0. After the '2' edge: channel=42, tens=4, units=2, one ch_changed pulse, entry_active=0.
3. Timeout (TIMEOUT_CYC=8): key 7, then no keys -> channel=7 exactly 8 edges later. With key 3 on that same edge, channel=73 and there is no separate timeout commit.
4. Wrap: at channel=99, CH_UP -> 1. At channel=1, CH_DOWN -> 99. Each gives one ch_changed pulse.
5. Invalid entry: keys 0, 0 -> discarded; channel unchanged, no pulse, digits restored. Current channel re-entered (e.g., 4, 2 at 42) -> no pulse.
6. Abort and recall: key 5 then CH_UP at 10 -> 11. With LAST_CH_EN, RECALL -> 10, RECALL again -> 11; without it, RECALL -> no change.

Source files
------------

// File: rtl/channel_entry_ctrl.sv
// Remote-control channel controller: two-digit entry with timeout, CH+/CH- wrap, BCD digit outputs.
// Optional LAST_CH_EN macro adds a RECALL key (code 13) that swaps with the previously viewed channel.
module channel_entry_ctrl #(
   parameter int MIN_CH      = 1,
   parameter int MAX_CH      = 99,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [7:0] unit_digit,
   output logic [7:0] tens_digit,
   output logic [6:0] channel,
   output logic       ch_changed,
   output logic       entry_active
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [6:0] MIN_C     = 7'(MIN_CH);
   localparam logic [6:0] MAX_C     = 7'(MAX_CH);
   localparam logic [3:0] RST_TENS  = 4'(MIN_CH / 10);
   localparam logic [3:0] RST_UNIT  = 4'(MIN_CH % 10);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FIRST = 1'b1;

   localparam logic [3:0] KEY_UP    = 4'd10;
   localparam logic [3:0] KEY_DOWN  = 4'd11;
   localparam logic [3:0] KEY_ENTER = 4'd12;
`ifdef LAST_CH_EN
   localparam logic [3:0] KEY_RECALL = 4'd13;
`endif

   logic [0:0]       state, state_nxt;
   logic [3:0]       pending, pending_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [6:0]       channel_nxt;
   logic [3:0]       tens_q, unit_q, tens_nxt, unit_nxt;
   logic [6:0]       candidate;
   logic [6:0]       ch_up_val, ch_dn_val;
   logic             is_digit, is_up, is_down, is_enter;
`ifdef LAST_CH_EN
   logic [6:0]       prev_ch;
   logic             is_recall;
`endif

   function automatic logic in_range(input logic [6:0] v);
      return (v >= MIN_C) && (v <= MAX_C);
   endfunction

   // Key decode and the wrap-around neighbours of the committed channel
   always_comb begin
      is_digit  = key_valid && (key_code <= 4'd9);
      is_up     = key_valid && (key_code == KEY_UP);
      is_down   = key_valid && (key_code == KEY_DOWN);
      is_enter  = key_valid && (key_code == KEY_ENTER);
`ifdef LAST_CH_EN
      is_recall = key_valid && (key_code == KEY_RECALL);
`endif
      ch_up_val = (channel == MAX_C) ? MIN_C : channel + 7'd1;
      ch_dn_val = (channel == MIN_C) ? MAX_C : channel - 7'd1;
      candidate = ({3'b000, pending} * 7'd10) + {3'b000, key_code};
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      count_nxt   = count;
      channel_nxt = channel;
      case (state)
         ST_IDLE: begin
            if (is_digit) begin
               pending_nxt = key_code;
               count_nxt   = '0;
               state_nxt   = ST_FIRST;
            end else if (is_up) begin
               channel_nxt = ch_up_val;
            end else if (is_down) begin
               channel_nxt = ch_dn_val;
`ifdef LAST_CH_EN
            end else if (is_recall) begin
               channel_nxt = prev_ch;
`endif
            end
         end
         ST_FIRST: begin
            state_nxt = ST_IDLE;
            if (is_digit) begin
               if (in_range(candidate)) channel_nxt = candidate;
            end else if (is_up) begin
               channel_nxt = ch_up_val;
            end else if (is_down) begin
               channel_nxt = ch_dn_val;
            end else if (is_enter) begin
               if (in_range({3'b000, pending})) channel_nxt = {3'b000, pending};
`ifdef LAST_CH_EN
            end else if (is_recall) begin
               channel_nxt = prev_ch;
`endif
            end else if (count == CNT_LAST) begin
               // Reserved codes fall through here too, so they never stall the timeout
               if (in_range({3'b000, pending})) channel_nxt = {3'b000, pending};
            end else begin
               count_nxt = count + CNT_ONE;
               state_nxt = ST_FIRST;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // During entry the display shows the pending digit; otherwise the committed channel
      if (state_nxt == ST_FIRST) begin
         tens_nxt = 4'd0;
         unit_nxt = pending_nxt;
      end else begin
         tens_nxt = 4'(channel_nxt / 7'd10);
         unit_nxt = 4'(channel_nxt % 7'd10);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pending      <= 4'd0;
         count        <= '0;
         channel      <= MIN_C;
         tens_q       <= RST_TENS;
         unit_q       <= RST_UNIT;
         ch_changed   <= 1'b0;
         entry_active <= 1'b0;
      end else begin
         state        <= state_nxt;
         pending      <= pending_nxt;
         count        <= count_nxt;
         channel      <= channel_nxt;
         tens_q       <= tens_nxt;
         unit_q       <= unit_nxt;
         ch_changed   <= (channel_nxt != channel);
         entry_active <= (state_nxt == ST_FIRST);
      end
   end

`ifdef LAST_CH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ch <= MIN_C;
      end else if (channel_nxt != channel) begin
         prev_ch <= channel;
      end
   end
`endif

   assign tens_digit = {4'b0000, tens_q};
   assign unit_digit = {4'b0000, unit_q};

endmodule

// File: tb/tb_channel_entry_ctrl.sv
// Self-checking bench for channel_entry_ctrl: directed scenarios plus random keys against a behavioural model.
module tb_channel_entry_ctrl;

   localparam int T    = 8;
   localparam int MINC = 1;
   localparam int MAXC = 99;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [7:0] unit_digit, tens_digit;
   logic [6:0] channel;
   logic       ch_changed, entry_active;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Behavioural model: committed channel, previous channel, entry in progress with its age
   int m_ch, m_prev, m_pend, m_age;
   bit m_entry, m_changed;

   channel_entry_ctrl #(.MIN_CH(MINC), .MAX_CH(MAXC), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .unit_digit(unit_digit), .tens_digit(tens_digit), .channel(channel),
      .ch_changed(ch_changed), .entry_active(entry_active)
   );

   always #5 clk = ~clk;

   function automatic void commitCand(input int c);
      if (c >= MINC && c <= MAXC) m_ch = c;
   endfunction

   function automatic void modelStep(input bit v, input int code);
      int old;
      old = m_ch;
      if (v && code <= 9) begin
         if (!m_entry) begin
            m_entry = 1'b1; m_pend = code; m_age = 0;
         end else begin
            commitCand(m_pend * 10 + code); m_entry = 1'b0;
         end
      end else if (v && (code == 10 || code == 11)) begin
         m_entry = 1'b0;
         if (code == 10) m_ch = (m_ch == MAXC) ? MINC : m_ch + 1;
         else            m_ch = (m_ch == MINC) ? MAXC : m_ch - 1;
      end else if (v && code == 12) begin
         if (m_entry) begin commitCand(m_pend); m_entry = 1'b0; end
`ifdef LAST_CH_EN
      end else if (v && code == 13) begin
         m_entry = 1'b0; m_ch = m_prev;
`endif
      end else if (m_entry) begin
         m_age++;
         if (m_age == T) begin commitCand(m_pend); m_entry = 1'b0; end
      end
      m_changed = (m_ch != old);
      if (m_changed) m_prev = old;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ch = MINC; m_prev = MINC; m_pend = 0; m_age = 0;
         m_entry = 1'b0; m_changed = 1'b0;
      end else begin
         modelStep(key_valid, int'(key_code));
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (check_en && rst_n) begin
         checkOutput("cyc_channel", 32'(channel), m_ch);
         checkOutput("cyc_tens", 32'(tens_digit), m_entry ? 0 : m_ch / 10);
         checkOutput("cyc_unit", 32'(unit_digit), m_entry ? m_pend : m_ch % 10);
         checkOutput("cyc_changed", 32'(ch_changed), int'(m_changed));
         checkOutput("cyc_entry", 32'(entry_active), int'(m_entry));
      end
   end

   // Caller sits on a negedge; the key is taken at the next posedge and we return on the following negedge
   task automatic applyStimulus(input logic [3:0] code);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r;
      int c;
      rst_n = 1'b0;
      idleCycles(2);
      checkOutput("rst_channel", 32'(channel), 1);
      checkOutput("rst_tens", 32'(tens_digit), 0);
      checkOutput("rst_unit", 32'(unit_digit), 1);
      checkOutput("rst_changed", 32'(ch_changed), 0);
      checkOutput("rst_entry", 32'(entry_active), 0);
      rst_n = 1'b1;
      check_en = 1'b1;

      applyStimulus(4'd4);
      checkOutput("entry4_active", 32'(entry_active), 1);
      checkOutput("entry4_unit", 32'(unit_digit), 4);
      checkOutput("entry4_tens", 32'(tens_digit), 0);
      applyStimulus(4'd2);
      checkOutput("entry42_channel", 32'(channel), 42);
      checkOutput("entry42_tens", 32'(tens_digit), 4);
      checkOutput("entry42_unit", 32'(unit_digit), 2);
      checkOutput("entry42_pulse", 32'(ch_changed), 1);
      checkOutput("entry42_active", 32'(entry_active), 0);
      idleCycles(1);
      checkOutput("entry42_pulse_end", 32'(ch_changed), 0);

      applyStimulus(4'd4);
      applyStimulus(4'd2);
      checkOutput("reenter_pulse", 32'(ch_changed), 0);
      applyStimulus(4'd0);
      applyStimulus(4'd0);
      checkOutput("bad00_channel", 32'(channel), 42);
      checkOutput("bad00_pulse", 32'(ch_changed), 0);
      checkOutput("bad00_tens", 32'(tens_digit), 4);
      checkOutput("bad00_unit", 32'(unit_digit), 2);

      applyStimulus(4'd7);
      idleCycles(T - 1);
      checkOutput("tmo_before_entry", 32'(entry_active), 1);
      checkOutput("tmo_before_channel", 32'(channel), 42);
      idleCycles(1);
      checkOutput("tmo_channel", 32'(channel), 7);
      checkOutput("tmo_pulse", 32'(ch_changed), 1);

      applyStimulus(4'd7);
      idleCycles(T - 1);
      applyStimulus(4'd3);
      checkOutput("race_channel", 32'(channel), 73);
      idleCycles(T + 2);
      checkOutput("race_after_channel", 32'(channel), 73);
      checkOutput("race_after_entry", 32'(entry_active), 0);

      applyStimulus(4'd9);
      applyStimulus(4'd9);
      checkOutput("ch99", 32'(channel), 99);
      applyStimulus(4'd10);
      checkOutput("wrap_up", 32'(channel), 1);
      checkOutput("wrap_up_pulse", 32'(ch_changed), 1);
      applyStimulus(4'd11);
      checkOutput("wrap_down", 32'(channel), 99);
      checkOutput("wrap_down_pulse", 32'(ch_changed), 1);

      applyStimulus(4'd1);
      applyStimulus(4'd0);
      checkOutput("ch10", 32'(channel), 10);
      applyStimulus(4'd5);
      applyStimulus(4'd10);
      checkOutput("abort_up", 32'(channel), 11);
      checkOutput("abort_up_entry", 32'(entry_active), 0);
      checkOutput("abort_up_unit", 32'(unit_digit), 1);
      applyStimulus(4'd13);
`ifdef LAST_CH_EN
      checkOutput("recall1", 32'(channel), 10);
`else
      checkOutput("recall1", 32'(channel), 11);
`endif
      applyStimulus(4'd13);
      checkOutput("recall2", 32'(channel), 11);

      applyStimulus(4'd0);
      applyStimulus(4'd12);
      checkOutput("enter0_channel", 32'(channel), 11);
      checkOutput("enter0_pulse", 32'(ch_changed), 0);
      applyStimulus(4'd9);
      applyStimulus(4'd12);
      checkOutput("enter9_channel", 32'(channel), 9);
      applyStimulus(4'd12);
      checkOutput("idle_enter_pulse", 32'(ch_changed), 0);
      applyStimulus(4'd14);
      checkOutput("reserved_channel", 32'(channel), 9);

      applyStimulus(4'd5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_channel", 32'(channel), 1);
      checkOutput("midrst_unit", 32'(unit_digit), 1);
      checkOutput("midrst_entry", 32'(entry_active), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 50) begin
            c = $urandom_range(0, 21);
            if (c > 15) c = $urandom_range(0, 9);
            applyStimulus(4'(c));
         end else if (r < 56) begin
            idleCycles($urandom_range(T - 2, T + 2));
         end else if (r < 57) begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            idleCycles(1);
         end
      end

      idleCycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
